// File: rtl/max7219_scroller.sv
// max7219_scroller: 8-column scroll engine emitting MAX7219 init words and 16-bit digit-register frames.
// Optional macro MAX_BLANK_FILL_EN: shift in a blank column when no data is offered at fetch time.
module max7219_scroller #(
  parameter int unsigned SCROLL_DIV = 1_000_000,
  parameter logic [3:0]  INTENSITY  = 4'h7,
  parameter logic [2:0]  SCAN_LIMIT = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);
  localparam int unsigned      CNT_W    = $clog2(SCROLL_DIV + 1);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FETCH, ST_SEND} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       idx_reg, idx_next;
  logic [2:0]       idx_inc;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       frame_buf_reg [8];
  logic [7:0]       frame_buf_next [8];
  logic [15:0]      out_word_reg, out_word_next;
  logic             out_valid_reg, out_valid_next;
  logic             in_ready_reg, in_ready_next;
  logic             frame_done_reg, frame_done_next;
  logic             shift_en;
  logic [7:0]       shift_data;
  logic             tick;
  logic             accept;

  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h0900;
      3'd2:    init_word = {8'h0A, 4'h0, INTENSITY};
      3'd3:    init_word = {8'h0B, 5'h00, SCAN_LIMIT};
      default: init_word = 16'h0F00;
    endcase
  endfunction

  assign accept  = out_valid_reg && out_ready;
  assign tick    = (state_reg != ST_INIT) && (cnt_reg == TICK_MAX);
  assign idx_inc = idx_reg + 3'd1;

  // Tick counter is frozen during INIT so the first scroll period starts at IDLE entry.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (state_reg == ST_INIT || cnt_reg == TICK_MAX) begin
      cnt_next = '0;
    end
  end

  assign frame_buf_next[0] = shift_en ? shift_data : frame_buf_reg[0];
  for (genvar gi = 1; gi < 8; gi++) begin : g_shift
    assign frame_buf_next[gi] = shift_en ? frame_buf_reg[gi-1] : frame_buf_reg[gi];
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    out_valid_next  = out_valid_reg;
    out_word_next   = out_word_reg;
    frame_done_next = 1'b0;
    shift_en        = 1'b0;
    shift_data      = in_data;
    case (state_reg)
      ST_INIT: begin
        if (!out_valid_reg) begin
          out_valid_next = 1'b1;
          out_word_next  = init_word(idx_reg);
        end else if (accept) begin
          if (idx_reg == 3'd4) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
            idx_next       = '0;
          end else begin
            idx_next      = idx_inc;
            out_word_next = init_word(idx_inc);
          end
        end
      end
      ST_IDLE: begin
        if (tick) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (in_valid && in_ready_reg) begin
          shift_en = 1'b1;
        end
`ifdef MAX_BLANK_FILL_EN
        else begin
          shift_en   = 1'b1;
          shift_data = 8'h00;
        end
`endif
        // The new column lands in buf[0], so it is also the first digit word.
        if (shift_en) begin
          state_next     = ST_SEND;
          idx_next       = '0;
          out_valid_next = 1'b1;
          out_word_next  = {8'h01, shift_data};
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (idx_reg == 3'd7) begin
            state_next      = ST_IDLE;
            out_valid_next  = 1'b0;
            frame_done_next = 1'b1;
          end else begin
            idx_next      = idx_inc;
            out_word_next = {{5'd0, idx_inc} + 8'd1, frame_buf_reg[idx_inc]};
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign in_ready_next = (state_next == ST_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_INIT;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      out_word_reg   <= 16'h0000;
      out_valid_reg  <= 1'b0;
      in_ready_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      for (int i = 0; i < 8; i++) frame_buf_reg[i] <= 8'h00;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      out_word_reg   <= out_word_next;
      out_valid_reg  <= out_valid_next;
      in_ready_reg   <= in_ready_next;
      frame_done_reg <= frame_done_next;
      for (int i = 0; i < 8; i++) frame_buf_reg[i] <= frame_buf_next[i];
    end
  end

  assign out_word   = out_word_reg;
  assign out_valid  = out_valid_reg;
  assign in_ready   = in_ready_reg;
  assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_max7219_scroller.sv
// Bench for max7219_scroller: expected-word queue model checked every cycle, plus directed literal checks.
module tb_max7219_scroller;
  localparam int SD = 4;
  localparam logic [15:0] INIT_W [5] = '{16'h0C01, 16'h0900, 16'h0A07, 16'h0B07, 16'h0F00};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic        bp_mode;

  max7219_scroller #(.SCROLL_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int ir_high = 0;
  logic [15:0] exp_q [$];
  logic [15:0] acc_log [$];
  int          acc_cyc [$];
  int          ir_cyc [$];
  logic [7:0]  mbuf [8];
  logic        fd_expect, stall_prev, ir_prev;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] acc_word(input int k);
    return (k < acc_log.size()) ? acc_log[k] : 16'hDEAD;
  endfunction

  function automatic int acc_c(input int k);
    return (k < acc_cyc.size()) ? acc_cyc[k] : -1;
  endfunction

  // A new column enters on the left; the whole 8-column picture is then due, digit 1 first.
  function automatic void model_shift(input logic [7:0] d);
    for (int k = 7; k > 0; k--) mbuf[k] = mbuf[k-1];
    mbuf[0] = d;
    for (int k = 0; k < 8; k++) exp_q.push_back({8'(k + 1), mbuf[k]});
  endfunction

  initial begin : compare
    fd_expect = 1'b0; stall_prev = 1'b0; ir_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", 32'(out_word), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back(INIT_W[k]);
        for (int k = 0; k < 8; k++) mbuf[k] = 8'h00;
        fd_expect = 1'b0; stall_prev = 1'b0; ir_prev = 1'b0;
      end else begin
        chk("frame_done", 32'(frame_done), 32'(fd_expect));
        if (frame_done) fd_cnt++;
        fd_expect = 1'b0;
        if (stall_prev) chk("valid_held_while_stalled", 32'(out_valid), 32'd1);
        if (out_valid) begin
          chk("in_ready_while_sending", 32'(in_ready), 32'd0);
          chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("out_word", 32'(out_word), 32'(exp_q[0]));
          if (out_ready) begin
            $display("cycle %0d: word %04h accepted", cyc, out_word);
            acc_log.push_back(out_word);
            acc_cyc.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (out_word[15:8] == 8'h08) fd_expect = 1'b1;
          end
        end
        stall_prev = out_valid && !out_ready;
        if (in_ready && !ir_prev) ir_cyc.push_back(cyc);
        if (in_ready) ir_high++;
        ir_prev = in_ready;
        if (in_ready && in_valid) begin
          $display("cycle %0d: column %02h fetched", cyc, in_data);
          model_shift(in_data);
        end
`ifdef MAX_BLANK_FILL_EN
        else if (in_ready) begin
          $display("cycle %0d: blank column fetched", cyc);
          model_shift(8'h00);
        end
`endif
      end
    end
  end

  initial begin : ready_drv
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic wait_acc(input int n, input string name);
    int k;
    k = 0;
    while (acc_log.size() < n && k < 200) begin @(posedge clk); #1; k++; end
    chk({name, "_timeout"}, 32'(acc_log.size() >= n), 32'd1);
  endtask

  task automatic wait_frame(input string name);
    int start, k;
    start = fd_cnt; k = 0;
    while (fd_cnt == start && k < 200) begin @(posedge clk); #1; k++; end
    chk({name, "_frame_timeout"}, 32'(fd_cnt != start), 32'd1);
  endtask

  task automatic do_fetch(input logic [7:0] d);
    int k;
    in_valid = 1'b1; in_data = d; k = 0;
    while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("fetch_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [63:0] bytes, input bit contiguous);
    logic [15:0] e;
    for (int k = 0; k < 8; k++) begin
      e = {8'(k + 1), bytes[8*k +: 8]};
      chk($sformatf("%s_w%0d", name, k), 32'(acc_word(k)), 32'(e));
    end
    chk({name, "_count"}, 32'(acc_log.size()), 32'd8);
    if (contiguous) chk({name, "_span"}, 32'(acc_c(7) - acc_c(0)), 32'd7);
  endtask

  initial begin : stim
    int rel_cyc, init_last, k;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    in_valid = 1'b1; in_data = 8'hA5;  // offered during INIT; must wait for FETCH

    wait_acc(5, "init");
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) chk($sformatf("init_w%0d", i), 32'(acc_word(i)), 32'(INIT_W[i]));
    chk("init_first_edge", 32'(acc_c(0)), 32'(rel_cyc + 2));
    chk("init_back_to_back", 32'(acc_c(4) - acc_c(0)), 32'd4);
    chk("init_then_idle", 32'(out_valid), 32'd0);
    init_last = acc_c(4);
    acc_log.delete(); acc_cyc.delete(); ir_cyc.delete(); ir_high = 0;

    do_fetch(8'hA5);
    wait_frame("a5");
    chk("tick_latency", 32'((ir_cyc.size() > 0) ? ir_cyc[0] : -1), 32'(init_last + SD + 1));
    chk("in_ready_rises", 32'(ir_cyc.size()), 32'd1);
    chk("in_ready_cycles", 32'(ir_high), 32'd1);
    chk("fetch_to_send", 32'(acc_c(0)), 32'((ir_cyc.size() > 0) ? ir_cyc[0] + 1 : -1));
    check_frame("a5", 64'h0000_0000_0000_00A5, 1'b1);

    acc_log.delete(); acc_cyc.delete();
    do_fetch(8'h77);
    k = 0;
    while (!(out_valid && out_word[15:8] == 8'h04) && k < 100) begin @(posedge clk); #1; k++; end
    chk("reach_word4", 32'(out_word), 32'h0400);
    rst_n = 1'b0;
    #1;
    chk("rst_now_out_valid", 32'(out_valid), 32'd0);
    chk("rst_now_out_word", 32'(out_word), 32'd0);
    chk("rst_now_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk); #1;
    acc_log.delete(); acc_cyc.delete();
    rst_n = 1'b1;
    wait_acc(5, "replay");
    chk("replay_w0", 32'(acc_word(0)), 32'h0C01);
    chk("replay_w4", 32'(acc_word(4)), 32'h0F00);

    repeat (2) @(posedge clk); #1;
    acc_log.delete(); acc_cyc.delete();
    bp_mode = 1'b1;
    do_fetch(8'h11);
    wait_frame("bp");
    bp_mode = 1'b0;
    check_frame("after_reset", 64'h0000_0000_0000_0011, 1'b0);
    do_fetch(8'h22);
    wait_frame("f22");
    acc_log.delete(); acc_cyc.delete();
    do_fetch(8'h33);
    wait_frame("f33");
    check_frame("three", 64'h0000_0000_0011_2233, 1'b1);

    acc_log.delete(); acc_cyc.delete();
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("underrun_fetch_timeout", 32'(k < 50), 32'd1);
`ifdef MAX_BLANK_FILL_EN
    wait_frame("blank");
    check_frame("blank", 64'h0000_0000_1122_3300, 1'b1);
`else
    repeat (20) @(posedge clk); #1;
    chk("underrun_in_ready", 32'(in_ready), 32'd1);
    chk("underrun_valid", 32'(out_valid), 32'd0);
    chk("underrun_words", 32'(acc_log.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
